gfp_multiplier: RTL and testbench
=================================

// Module: gfp_multiplier
// PURPOSE
//  Sequential unsigned fixed-point multiplier, Q8.8 by default: P = A * B.
//  Inverse companion of the Goldschmidt fixed-point divider; used as its
//  self-check path (quotient * divisor ~= dividend) and as a general datapath
//  multiplier. Radix-2 shift-add, one multiplier bit per clock, start/done handshake.
// PARAMETERS
//  WIDTH  16  operand and result width in bits (unsigned)
//  FRAC    8  fractional bits in operands and result (FRAC < WIDTH)
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-low reset (0 = reset)
//  start  in   1      request; sampled only in IDLE
//  A      in   WIDTH  multiplicand, captured when start is accepted
//  B      in   WIDTH  multiplier, captured when start is accepted
//  busy   out  1      1 in RUN and DONE states
//  done   out  1      one-cycle pulse; P/ovf valid in that cycle
//  P      out  WIDTH  product, Q(WIDTH-FRAC).FRAC, held until the next result
//  ovf    out  1      1 = product saturated; held with P
// BEHAVIOUR
//  - Reset (asynchronous, reset=0): state=IDLE; busy=0, done=0, P=0, ovf=0;
//    accumulator, operand registers and counter cleared. Reset during RUN
//    aborts the operation; no done pulse is produced.
//  - FSM: IDLE -(start=1)-> RUN -(cnt==WIDTH-1)-> DONE -(always)-> IDLE.
//  - Accept edge (IDLE, start=1): A, B latched; acc(2*WIDTH)=0; cnt=0.
//  - Each RUN edge: if B_reg[0], acc += A_reg << cnt; B_reg >>= 1; cnt++.
//  - Last RUN edge (cnt==WIDTH-1) also registers P/ovf and enters DONE.
//    Latency: done=1 in the cycle after the WIDTH-th edge after the accept
//    edge; the next start is accepted no earlier than 1 cycle after done.
//  - Result: full = 2*WIDTH-bit product; r = full >> FRAC (plus rounding).
//    If r >= 2^WIDTH: P = all ones, ovf = 1; else P = r[WIDTH-1:0], ovf = 0.
//  - start while busy=1 is ignored (not queued); A/B changes during RUN have
//    no effect. A=0 or B=0 still takes the full latency; P=0, ovf=0.
//  - done is high exactly one cycle; P/ovf do not change until the next done.
// CONFIGURATION
//  - GFP_MULT_ROUND_EN defined: round half up; r = (full + 2^(FRAC-1)) >> FRAC,
//    computed at full+1 width so rounding carry into overflow is detected.
//  - Not defined: truncate; r = full >> FRAC.
//  - Latency and handshake are identical in both builds.
// TESTING
//  1. A=0x0100 (1.0), B=0x0200 (2.0), start -> done after 16 cycles, P=0x0200, ovf=0.
//  2. A=0x0080 (0.5), B=0x0280 (2.5) -> P=0x0140 (1.25), ovf=0.
//  3. A=0x1000, B=0x1000 (16*16) -> P=0xFFFF, ovf=1; A=0x0FFF, B=0x0FFF -> no ovf.
//  4. A=0x0001, B=0x0080 (full=0x0080) -> P=0x0001 with GFP_MULT_ROUND_EN, 0x0000 without.
//  5. start pulsed again at cycle 5 of RUN with new A/B -> ignored; one done, P from first pair.
//  6. reset=0 at cycle 8 of RUN -> busy=0, done never pulses, P=0; restart gives correct P.
//  Also: feed divider output No and D back as A/B; check |P - N| <= 2 LSB.

Source files
------------

// File: rtl/gfp_multiplier_if.sv
// Handshake and operand/result bundle for the sequential fixed-point multiplier.
// The master drives start/A/B; the slave (multiplier) returns busy/done/P/ovf.
interface gfp_multiplier_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] P;
  logic             ovf;

  modport master (output start, A, B, input busy, done, P, ovf);
  modport slave  (input start, A, B, output busy, done, P, ovf);
endinterface

// File: rtl/gfp_multiplier.sv
// Radix-2 shift-add unsigned Q(WIDTH-FRAC).FRAC multiplier, one multiplier bit per clock.
// Define GFP_MULT_ROUND_EN for round-half-up results; otherwise the product is truncated.
module gfp_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic               clk,
  input  logic               reset,
  gfp_multiplier_if.slave    bus
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   p_reg;
  logic               ovf_reg;
  logic [2*WIDTH:0]   rounded;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH-1:0]   p_calc;
  logic               ovf_calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final accumulation is folded into the result so P registers on the last RUN edge;
  // the extra top bit keeps a rounding carry from wrapping past the overflow check.
  always_comb begin
    acc_next = acc;
    if (b_reg[0]) acc_next = acc + ({{WIDTH{1'b0}}, a_reg} << cnt);
`ifdef GFP_MULT_ROUND_EN
    rounded = {1'b0, acc_next} + ((2*WIDTH+1)'(1) << (FRAC - 1));
`else
    rounded = {1'b0, acc_next};
`endif
    shifted  = rounded >> FRAC;
    ovf_calc = |shifted[2*WIDTH:WIDTH];
    p_calc   = ovf_calc ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      p_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            p_reg   <= p_calc;
            ovf_reg <= ovf_calc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.P    = p_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_gfp_multiplier.sv
// Directed and randomized checks of gfp_multiplier against an arithmetic reference model.
// Build with GFP_MULT_ROUND_EN defined to check the rounding variant.
module tb_gfp_multiplier;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  logic clk;
  logic reset;
  int   passCount;
  int   failCount;
  int   checkCount;

  gfp_multiplier_if #(.WIDTH(WIDTH)) bus ();

  gfp_multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, optional half-LSB bias, shift, saturate.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned full;
    longint unsigned r;
    full = longint'(a) * longint'(b);
`ifdef GFP_MULT_ROUND_EN
    full = full + (64'd1 << (FRAC - 1));
`endif
    r = full >> FRAC;
    if (r >= (64'd1 << WIDTH)) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, r[WIDTH-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Full transaction: latency, result, then the one-cycle done pulse with P/ovf held.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int cycles;
    logic [WIDTH:0] exp;
    exp = model(a, b);
    applyStimulus(a, b);
    checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd1);
    waitDone(cycles);
    checkOutput({tag, ".latency"}, 64'(cycles), 64'(WIDTH));
    checkOutput({tag, ".P"}, 64'(bus.P), 64'(exp[WIDTH-1:0]));
    checkOutput({tag, ".ovf"}, 64'(bus.ovf), 64'(exp[WIDTH]));
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 64'(bus.done), 64'd0);
    checkOutput({tag, ".hold"}, 64'({bus.ovf, bus.P}), 64'(exp));
  endtask

  initial begin
    int cycles;
    int doneSeen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   exp;
    longint           diff;

    passCount  = 0;
    failCount  = 0;
    checkCount = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.state", 64'({bus.busy, bus.done, bus.ovf, bus.P}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    runOp("one_x_two", 16'h0100, 16'h0200);
    checkOutput("one_x_two.const", 64'(bus.P), 64'h0200);
    runOp("half_x_2p5", 16'h0080, 16'h0280);
    checkOutput("half_x_2p5.const", 64'(bus.P), 64'h0140);
    runOp("sat", 16'h1000, 16'h1000);
    checkOutput("sat.const", 64'({bus.ovf, bus.P}), 64'h1FFFF);
    runOp("nosat", 16'h0FFF, 16'h0FFF);
    checkOutput("nosat.ovf", 64'(bus.ovf), 64'd0);
    runOp("round", 16'h0001, 16'h0080);
`ifdef GFP_MULT_ROUND_EN
    checkOutput("round.const", 64'(bus.P), 64'h0001);
`else
    checkOutput("round.const", 64'(bus.P), 64'h0000);
`endif
    runOp("zeroA", 16'h0000, 16'hBEEF);
    runOp("zeroB", 16'h1234, 16'h0000);
    runOp("maxmax", 16'hFFFF, 16'hFFFF);

    // A second start mid-run must be dropped and the first operands kept.
    exp = model(16'h0340, 16'h0180);
    applyStimulus(16'h0340, 16'h0180);
    repeat (3) @(negedge clk);
    bus.A     = 16'h7777;
    bus.B     = 16'h2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cycles);
    checkOutput("ignore.latency", 64'(cycles), 64'(WIDTH - 4));
    checkOutput("ignore.result", 64'({bus.ovf, bus.P}), 64'(exp));
    doneSeen = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    checkOutput("ignore.singleDone", 64'(doneSeen), 64'd0);
    checkOutput("ignore.idle", 64'(bus.busy), 64'd0);

    // Reset mid-run aborts with no done pulse, then a restart works.
    applyStimulus(16'h0A00, 16'h0300);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort.state", 64'({bus.busy, bus.done, bus.ovf, bus.P}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    doneSeen = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    checkOutput("abort.noDone", 64'(doneSeen), 64'd0);
    checkOutput("abort.P", 64'(bus.P), 64'd0);
    runOp("restart", 16'h0A00, 16'h0300);

    for (int i = 0; i < 10; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 3 != 0) begin
        ra = ra >> $urandom_range(3, 10);
        rb = rb >> $urandom_range(3, 10);
      end
      runOp($sformatf("rand%0d", i), ra, rb);
    end

    // Divider self-check path: quotient times divisor should recover the dividend.
    for (int i = 0; i < 4; i++) begin
      ra  = WIDTH'($urandom_range(16'h0001, 16'h7FFF));
      rb  = WIDTH'($urandom_range(16'h0100, 16'h01FF));
      quo = WIDTH'((longint'(ra) << FRAC) / longint'(rb));
      runOp($sformatf("div%0d", i), quo, rb);
      diff = longint'(bus.P) - longint'(ra);
      if (diff < 0) diff = -diff;
      checkOutput($sformatf("div%0d.err", i), 64'(diff <= 2), 64'd1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
